// File: rtl/tdm_demux2_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tdm_demux2_if                                                |
// | Purpose  : Bundles the multiplexed input stream and the per-channel     |
// |            recovered outputs of tdm_demux2.                             |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
interface tdm_demux2_if #(
   parameter int DATA_W = 1,
   parameter int ERR_W  = 8
);
   logic              in_valid;
   logic              in_sof;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] out_1;
   logic [DATA_W-1:0] out_2;
   logic              out_1_valid;
   logic              out_2_valid;
   logic              pair_valid;
   logic              err_sync;
   logic [ERR_W-1:0]  err_cnt;
   logic              locked;

   // Link side: drives the multiplexed stream, observes the recovered channels
   modport master (
      output in_valid, in_sof, in_data,
      input  out_1, out_2, out_1_valid, out_2_valid, pair_valid,
      input  err_sync, err_cnt, locked
   );

   // Demultiplexer side
   modport slave (
      input  in_valid, in_sof, in_data,
      output out_1, out_2, out_1_valid, out_2_valid, pair_valid,
      output err_sync, err_cnt, locked
   );
endinterface
`default_nettype wire

// File: rtl/tdm_demux2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tdm_demux2                                                   |
// | Purpose  : 2:1 TDM demultiplexer. Recovers channel-1/channel-2 samples  |
// |            from a start-of-frame marked stream, tracks frame alignment, |
// |            flags/counts sync errors and strobes completed frames.       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tdm_demux2 #(
   parameter int DATA_W = 1,
   parameter int ERR_W  = 8
) (
   input  wire           sys_clk,
   input  wire           sys_rst_n,
   tdm_demux2_if.slave   bus
);

   localparam logic [1:0] ST_SEARCH = 2'd0;   // no alignment
   localparam logic [1:0] ST_EXP_2  = 2'd1;   // channel 1 held, waiting for channel 2
   localparam logic [1:0] ST_EXP_1  = 2'd2;   // frame complete, waiting for channel 1

   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   logic [1:0]        state_q,       state_d;
   logic [DATA_W-1:0] out_1_q,       out_1_d;
   logic [DATA_W-1:0] out_2_q,       out_2_d;
   logic              out_1_valid_q, out_1_valid_d;
   logic              out_2_valid_q, out_2_valid_d;
   logic              pair_valid_q,  pair_valid_d;
   logic              err_sync_q,    err_sync_d;
   logic [ERR_W-1:0]  err_cnt_q,     err_cnt_d;
   logic              locked_q,      locked_d;

   // Next-state decode: steer each valid sample according to frame alignment
   always_comb begin
      state_d       = state_q;
      out_1_d       = out_1_q;
      out_2_d       = out_2_q;
      out_1_valid_d = 1'b0;
      out_2_valid_d = 1'b0;
      pair_valid_d  = 1'b0;
      err_sync_d    = 1'b0;

      if (bus.in_valid) begin
         case (state_q)
            ST_SEARCH: begin
               // Channel-2 samples seen before any frame start are dropped quietly
               if (bus.in_sof) begin
                  out_1_d       = bus.in_data;
                  out_1_valid_d = 1'b1;
                  state_d       = ST_EXP_2;
               end
            end
            ST_EXP_2: begin
               if (bus.in_sof) begin
                  // Channel 2 went missing: restart the frame on the new channel-1 sample
                  err_sync_d    = 1'b1;
                  out_1_d       = bus.in_data;
                  out_1_valid_d = 1'b1;
               end else begin
                  out_2_d       = bus.in_data;
                  out_2_valid_d = 1'b1;
                  pair_valid_d  = 1'b1;
                  state_d       = ST_EXP_1;
               end
            end
            ST_EXP_1: begin
               if (bus.in_sof) begin
                  out_1_d       = bus.in_data;
                  out_1_valid_d = 1'b1;
                  state_d       = ST_EXP_2;
               end else begin
                  // Surplus channel-2 sample: alignment is no longer trusted
                  err_sync_d = 1'b1;
                  state_d    = ST_SEARCH;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end

      locked_d  = (state_d != ST_SEARCH);
      err_cnt_d = err_cnt_q;
      if (err_sync_d && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_ONE;
      end
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= ST_SEARCH;
         out_1_q       <= '0;
         out_2_q       <= '0;
         out_1_valid_q <= 1'b0;
         out_2_valid_q <= 1'b0;
         pair_valid_q  <= 1'b0;
         err_sync_q    <= 1'b0;
         err_cnt_q     <= '0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_1_q       <= out_1_d;
         out_2_q       <= out_2_d;
         out_1_valid_q <= out_1_valid_d;
         out_2_valid_q <= out_2_valid_d;
         pair_valid_q  <= pair_valid_d;
         err_sync_q    <= err_sync_d;
         err_cnt_q     <= err_cnt_d;
         locked_q      <= locked_d;
      end
   end

   assign bus.out_1       = out_1_q;
   assign bus.out_2       = out_2_q;
   assign bus.out_1_valid = out_1_valid_q;
   assign bus.out_2_valid = out_2_valid_q;
   assign bus.pair_valid  = pair_valid_q;
   assign bus.err_sync    = err_sync_q;
   assign bus.err_cnt     = err_cnt_q;
   assign bus.locked      = locked_q;

endmodule
`default_nettype wire
